// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//   Samples an N-bit Johnson counter state each valid cycle. It checks that the
//   code is one of the 2N legal codes and that each step advances by one phase.
//   It decodes the code to a phase index and a one-hot phase enable. Illegal
//   codes and out-of-sequence steps are pulsed, counted with saturation, and
//   held in a sticky flag. All outputs are registered, one cycle after the sample.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   jc_valid, jc_load   sample strobe; load suppresses the step check
//   jc_in[N]            Johnson counter state
//   clr_err             clears err_sticky / err_count (an error the same cycle wins)
//   phase_valid         phase_idx / phase_onehot hold a legal decoded phase
//   phase_idx[IW]       decoded phase 0..2N-1
//   phase_onehot[2N]    one bit per phase, zero when not valid
//   wrap_pulse          in-sequence step 2N-1 -> 0
//   illegal_code        sampled code is not a legal Johnson code
//   seq_error           legal code that is not prev+1 (mod 2N)
//   locked              decoder is tracking the counter
//   err_sticky          any error since the last clear
//   err_count[ERR_W]    saturating error count
module johnson_phase_decoder #(
   parameter int N     = 4,
   parameter int ERR_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   jc_valid,
   input  logic                   jc_load,
   input  logic [N-1:0]           jc_in,
   input  logic                   clr_err,
   output logic                   phase_valid,
   output logic [$clog2(2*N)-1:0] phase_idx,
   output logic [2*N-1:0]         phase_onehot,
   output logic                   wrap_pulse,
   output logic                   illegal_code,
   output logic                   seq_error,
   output logic                   locked,
   output logic                   err_sticky,
   output logic [ERR_W-1:0]       err_count
);

   localparam int P  = 2 * N;
   localparam int IW = $clog2(P);
   localparam logic [IW-1:0] LAST = IW'(P - 1);

   typedef enum logic {SYNC, LOCKED} state_t;
   state_t state;

   // Phase p <= N: p ones filled from the MSB; phase N+m: m zeros from the MSB.
   function automatic logic [N-1:0] phase_code(input int p);
      logic [N-1:0] c;
      for (int i = 0; i < N; i++)
         c[i] = (p <= N) ? (i >= N - p) : (i < P - p);
      return c;
   endfunction

   logic          dec_legal;
   logic [IW-1:0] dec_idx;
   logic [IW-1:0] next_idx;
   logic          step_ok;
   logic          err_ev;

   always_comb begin
      dec_legal = 1'b0;
      dec_idx   = '0;
      for (int p = 0; p < P; p++) begin
         if (jc_in == phase_code(p)) begin
            dec_legal = 1'b1;
            dec_idx   = IW'(p);
         end
      end
   end

   // 2N need not be a power of two, so wrap explicitly rather than by overflow.
   assign next_idx = (phase_idx == LAST) ? '0 : phase_idx + 1'b1;
   assign step_ok  = (dec_idx == next_idx);
   assign err_ev   = jc_valid & (~dec_legal |
                     ((state == LOCKED) & ~jc_load & ~step_ok));
   assign locked   = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= SYNC;
         phase_valid  <= 1'b0;
         phase_idx    <= '0;
         phase_onehot <= '0;
         wrap_pulse   <= 1'b0;
         illegal_code <= 1'b0;
         seq_error    <= 1'b0;
         err_sticky   <= 1'b0;
         err_count    <= '0;
      end else begin
         wrap_pulse   <= 1'b0;
         illegal_code <= 1'b0;
         seq_error    <= 1'b0;

         if (jc_valid) begin
            if (!dec_legal) begin
               // phase_idx intentionally holds; only the valid/enable drop.
               illegal_code <= 1'b1;
               phase_valid  <= 1'b0;
               phase_onehot <= '0;
               state        <= SYNC;
            end else begin
               if (state == LOCKED && !jc_load) begin
                  if (step_ok) wrap_pulse <= (phase_idx == LAST);
                  else         seq_error  <= 1'b1;
               end
               phase_idx    <= dec_idx;
               phase_onehot <= P'(1) << dec_idx;
               phase_valid  <= 1'b1;
               state        <= LOCKED;
            end
         end

         // A same-cycle error beats the clear: the count restarts at one.
         if (err_ev) begin
            err_sticky <= 1'b1;
            if (clr_err)                      err_count <= ERR_W'(1);
            else if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
         end else if (clr_err) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
         end
      end
   end

endmodule
